// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single fixed-latency memory.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed data priority.
module mem_arbiter #(
    parameter int unsigned LAT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic [31:0] f_rdata,
    output logic        f_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;  // 1 = data port owns the access
    logic        m_en_q, m_en_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [31:0] f_rdata_q, f_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        f_valid_q, f_valid_d;
    logic        d_valid_q, d_valid_d;
    logic        busy_q, busy_d;
    logic        pick_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic        rr_q, rr_d;  // 1 = data wins the next tie

    assign pick_d = d_req & (~f_req | rr_q);
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        m_en_d    = 1'b0;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;
        f_valid_d = 1'b0;
        d_valid_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        rr_d      = rr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (f_req || d_req) begin
                    state_d  = StWait;
                    cnt_d    = 4'(LAT - 1);
                    owner_d  = pick_d;
                    m_en_d   = 1'b1;
                    m_addr_d = pick_d ? d_addr : f_addr;
                    m_we_d   = pick_d & d_we;
                    if (pick_d) begin
                        m_wdata_d = d_wdata;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    rr_d = ~pick_d;
`endif
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                    if (owner_q) begin
                        d_valid_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdata_d = m_rdata;
                        end
                    end else begin
                        f_valid_d = 1'b1;
                        f_rdata_d = m_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            owner_q   <= 1'b0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= 32'd0;
            m_wdata_q <= 32'd0;
            f_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
            f_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q      <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            m_en_q    <= m_en_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
            f_valid_q <= f_valid_d;
            d_valid_q <= d_valid_d;
            busy_q    <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q      <= rr_d;
`endif
        end
    end

    assign f_rdata = f_rdata_q;
    assign f_valid = f_valid_q;
    assign d_rdata = d_rdata_q;
    assign d_valid = d_valid_q;
    assign m_en    = m_en_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: interval-based transaction model checked every cycle,
// directed literal cases, randomized traffic with resets, and LAT=1/15 instances.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clock;
    logic        reset;
    logic        f_req, d_req, d_we;
    logic [31:0] f_addr, d_addr, d_wdata, m_rdata;
    logic [31:0] f_rdata, d_rdata, m_addr, m_wdata;
    logic        f_valid, d_valid, m_en, m_we, busy;

    // Shared stimulus and private outputs for the LAT=1 / LAT=15 instances.
    logic        d_req1, d_req15;
    logic [31:0] x_addr, mr1, mr15;
    logic [31:0] fr1, dr1, ma1, mw1, fr15, dr15, ma15, mw15;
    logic        fv1, dv1, me1, mwe1, b1, fv15, dv15, me15, mwe15, b15;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_valid(f_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    mem_arbiter #(.LAT(1)) dut1 (
        .clock(clock), .reset(reset),
        .f_req(1'b0), .f_addr(32'd0), .f_rdata(fr1), .f_valid(fv1),
        .d_req(d_req1), .d_we(1'b0), .d_addr(x_addr), .d_wdata(32'd0),
        .d_rdata(dr1), .d_valid(dv1),
        .m_en(me1), .m_we(mwe1), .m_addr(ma1), .m_wdata(mw1),
        .m_rdata(mr1), .busy(b1)
    );

    mem_arbiter #(.LAT(15)) dut15 (
        .clock(clock), .reset(reset),
        .f_req(1'b0), .f_addr(32'd0), .f_rdata(fr15), .f_valid(fv15),
        .d_req(d_req15), .d_we(1'b0), .d_addr(x_addr), .d_wdata(32'd0),
        .d_rdata(dr15), .d_valid(dv15),
        .m_en(me15), .m_we(mwe15), .m_addr(ma15), .m_wdata(mw15),
        .m_rdata(mr15), .busy(b15)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL timeout reached before end of test");
        $fatal(1, "timeout");
    end

    // Model: a grant at edge g owns the memory for cycles g..g+LAT, valid in
    // the cycle after edge g+LAT, next grant allowed at edge g+LAT+2.
    logic [31:0] mem [16];
    int          t = 0;
    int          g = 0;
    bit          act, own_d, cur_we, rr, mdl_grant;
    logic [31:0] cur_addr, cap;
    logic [31:0] e_maddr, e_mwd, e_fr, e_dr;
    bit          e_men, e_mwe, e_fv, e_dv, e_busy;

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0d)", nm, act_v, exp_v, t);
        end
    endtask

    task automatic mdl_reset();
        act       = 1'b0;
        rr        = 1'b1;
        mdl_grant = 1'b0;
        e_men     = 1'b0;
        e_mwe     = 1'b0;
        e_maddr   = 32'd0;
        e_mwd     = 32'd0;
        e_fv      = 1'b0;
        e_dv      = 1'b0;
        e_fr      = 32'd0;
        e_dr      = 32'd0;
        e_busy    = 1'b0;
    endtask

    task automatic compare_all();
        chk("m_en", 32'(m_en), 32'(e_men));
        chk("m_we", 32'(m_we), 32'(e_mwe));
        chk("m_addr", m_addr, e_maddr);
        chk("m_wdata", m_wdata, e_mwd);
        chk("f_valid", 32'(f_valid), 32'(e_fv));
        chk("d_valid", 32'(d_valid), 32'(e_dv));
        chk("f_rdata", f_rdata, e_fr);
        chk("d_rdata", d_rdata, e_dr);
        chk("busy", 32'(busy), 32'(e_busy));
    endtask

    task automatic step();
        bit pd;
        @(posedge clock);
        #1;
        t++;
        mdl_grant = 1'b0;
        if (reset) begin
            mdl_reset();
        end else begin
            if (act && t == g + LAT && !cur_we) begin
                if (own_d) e_dr = cap;
                else e_fr = cap;
            end
            if ((!act || t >= g + LAT + 2) && (f_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
                pd = d_req && (!f_req || rr);
`else
                pd = d_req;
`endif
                rr        = !pd;
                act       = 1'b1;
                g         = t;
                own_d     = pd;
                mdl_grant = 1'b1;
                cur_addr  = pd ? d_addr : f_addr;
                cur_we    = pd && d_we;
                e_maddr   = cur_addr;
                e_mwe     = cur_we;
                if (pd) e_mwd = d_wdata;
                if (cur_we) mem[cur_addr[5:2]] = d_wdata;
            end
            e_men  = mdl_grant;
            e_busy = act && t <= g + LAT;
            e_fv   = act && t == g + LAT && !own_d;
            e_dv   = act && t == g + LAT && own_d;
        end
        compare_all();
        // Memory returns the word only in the cycle before the capture edge.
        if (!reset && act && t + 1 == g + LAT) begin
            cap     = mem[cur_addr[5:2]];
            m_rdata = cap;
        end else begin
            m_rdata = $urandom;
        end
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        mdl_reset();
        compare_all();
    endtask

    task automatic do_reset(input int n);
        async_reset();
        repeat (n) step();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] raddr();
        return $urandom & 32'hFFFF_FFFC;
    endfunction

    initial begin
        int          n;
        int          rst_cnt;
        logic [3:0]  order;
        int          done_cnt;
        int          v1, v15;

        reset   = 1'b0;
        f_req   = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        f_addr  = 32'd0;
        d_addr  = 32'd0;
        d_wdata = 32'd0;
        m_rdata = 32'd0;
        d_req1  = 1'b0;
        d_req15 = 1'b0;
        x_addr  = 32'd0;
        mr1     = 32'd0;
        mr15    = 32'd0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        #2;
        do_reset(1);

        // Single fetch, LAT=2.
        mem[0] = 32'h8C08_0004;
        f_addr = 32'h0000_0040;
        f_req  = 1'b1;
        step();
        chk("fetch_grant_m_en", 32'(m_en), 32'd1);
        chk("fetch_grant_m_addr", m_addr, 32'h0000_0040);
        chk("fetch_grant_m_we", 32'(m_we), 32'd0);
        n = 1;
        while (!f_valid && n < 10) begin
            step();
            n++;
        end
        chk("fetch_valid_cycle", n, 3);
        chk("fetch_rdata", f_rdata, 32'h8C08_0004);
        f_req = 1'b0;

        // Single store.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0100;
        d_wdata = 32'hDEAD_BEEF;
        n = 0;
        do begin
            step();
            n++;
        end while (!mdl_grant && n < 10);
        chk("store_m_en", 32'(m_en), 32'd1);
        chk("store_m_we", 32'(m_we), 32'd1);
        chk("store_m_wdata", m_wdata, 32'hDEAD_BEEF);
        n = 0;
        while (!d_valid && n < 10) begin
            step();
            n++;
        end
        chk("store_d_valid", 32'(d_valid), 32'd1);
        chk("store_d_rdata_kept", d_rdata, 32'd0);
        chk("store_f_valid_low", 32'(f_valid), 32'd0);
        d_req = 1'b0;
        d_we  = 1'b0;

        // Both requesters held for four accesses.
        do_reset(1);
        f_req  = 1'b1;
        f_addr = 32'h0000_0044;
        d_req  = 1'b1;
        d_addr = 32'h0000_0108;
        order  = 4'd0;
        done_cnt = 0;
        n = 0;
        while (done_cnt < 4 && n < 60) begin
            step();
            n++;
            if (f_valid || d_valid) begin
                order = {order[2:0], d_valid};
                done_cnt++;
            end
        end
        chk("tie_done_count", done_cnt, 4);
`ifdef ARB_ROUND_ROBIN_EN
        chk("tie_order", 32'(order), 32'h0000_000A);
`else
        chk("tie_order", 32'(order), 32'h0000_000F);
`endif
        f_req = 1'b0;
        d_req = 1'b0;

        // Reset during the WAIT of a load, then re-grant of the held request.
        do_reset(1);
        d_req  = 1'b1;
        d_addr = 32'h0000_010C;
        step();
        step();
        async_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_m_en", 32'(m_en), 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_regrant_m_en", 32'(m_en), 32'd1);
        n = 0;
        while (!d_valid && n < 10) begin
            step();
            n++;
        end
        d_req = 1'b0;
        step();
        step();

        // Data request arriving during a fetch's WAIT waits for IDLE.
        f_req  = 1'b1;
        f_addr = 32'h0000_0048;
        step();
        chk("late_fetch_grant", 32'(m_en), 32'd1);
        d_req  = 1'b1;
        d_addr = 32'h0000_014C;
        n = 0;
        do begin
            step();
            n++;
            if (f_valid) f_req = 1'b0;
        end while (!m_en && n < 12);
        chk("late_data_grant_delay", n, LAT + 2);
        chk("late_data_m_addr", m_addr, 32'h0000_014C);
        n = 0;
        while (!d_valid && n < 10) begin
            step();
            n++;
        end
        d_req = 1'b0;

        // Randomized traffic with occasional resets.
        rst_cnt = 0;
        for (int i = 0; i < 2500; i++) begin
            step();
            if (e_fv) begin
                if ($urandom_range(0, 1) == 0) f_req = 1'b0;
                else f_addr = raddr();
            end else if (!f_req && $urandom_range(0, 2) == 0) begin
                f_req  = 1'b1;
                f_addr = raddr();
            end
            if (e_dv || (!d_req && $urandom_range(0, 2) == 0)) begin
                d_req   = $urandom_range(0, 3) != 0;
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = raddr();
                d_wdata = $urandom;
            end
            if (reset) begin
                rst_cnt--;
                if (rst_cnt == 0) reset = 1'b0;
            end else if ($urandom_range(0, 149) == 0) begin
                async_reset();
                rst_cnt = $urandom_range(1, 3);
            end
        end
        f_req = 1'b0;
        d_req = 1'b0;
        reset = 1'b0;

        // LAT=1 and LAT=15 single loads, granted together at edge 1.
        @(posedge clock);
        #1;
        x_addr  = 32'h0000_0080;
        d_req1  = 1'b1;
        d_req15 = 1'b1;
        v1  = 0;
        v15 = 0;
        for (int e = 1; e <= 25; e++) begin
            @(posedge clock);
            #1;
            if (e == 1) begin
                chk("lat1_grant", 32'(me1), 32'd1);
                chk("lat15_grant", 32'(me15), 32'd1);
            end
            if (dv1 && v1 == 0) begin
                v1 = e;
                chk("lat1_rdata", dr1, 32'h1111_0001);
                d_req1 = 1'b0;
            end
            if (dv15 && v15 == 0) begin
                v15 = e;
                chk("lat15_rdata", dr15, 32'h1515_000F);
                d_req15 = 1'b0;
            end
            mr1  = (e == 1) ? 32'h1111_0001 : $urandom;
            mr15 = (e == 15) ? 32'h1515_000F : $urandom;
        end
        chk("lat1_valid_cycle", v1, 2);
        chk("lat15_valid_cycle", v15, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
